// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and operand-sign helpers.
package alu_muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // rs1 is treated as two's complement for these ops
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    // Ops that return the upper half of the double-width product
    function automatic logic op_is_mulh(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    // Requester side (EX stage / writeback)
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    // Unit side
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_sign_conv.sv
// Conditional two's-complement negate; turns signed operands into magnitudes
// at accept and re-applies the result sign at the end of an operation.
module muldiv_sign_conv #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] din,
    input  logic            neg,
    output logic [XLEN-1:0] dout
);
    logic signed [XLEN-1:0] din_s;
    logic signed [XLEN-1:0] neg_s;

    assign din_s = signed'(din);
    assign neg_s = -din_s;
    assign dout  = neg ? unsigned'(neg_s) : din;
endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit. One product/quotient bit per cycle
// on operand magnitudes, followed by a single sign-fix cycle. Division by
// zero and signed overflow short-circuit straight to DONE.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    output logic          busy,
    alu_muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              a_neg, b_neg, neg_d;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    logic [XLEN-1:0]   acc_hi, acc_lo;
    logic [XLEN-1:0]   fix_in, fix_neg, fix_res;

    assign accept = bus.in_valid & bus.in_ready & ~flush;

    // ---------------- accept: operand magnitudes and special cases ----------------
    assign a_neg = op_a_signed(bus.in_op) & bus.in_a[XLEN-1];
    assign b_neg = op_b_signed(bus.in_op) & bus.in_b[XLEN-1];
    // Remainder follows the dividend; quotient and product follow the sign XOR
    assign neg_d = op_is_rem(bus.in_op) ? a_neg : (a_neg ^ b_neg);

    muldiv_sign_conv #(.XLEN(XLEN)) u_abs_a (.din(bus.in_a), .neg(a_neg), .dout(a_mag));
    muldiv_sign_conv #(.XLEN(XLEN)) u_abs_b (.din(bus.in_b), .neg(b_neg), .dout(b_mag));

    assign div_zero = op_is_div(bus.in_op) && (bus.in_b == '0);
    assign div_ovf  = ((bus.in_op == MD_DIV) || (bus.in_op == MD_REM))
                    && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
                    && (&bus.in_b);
    assign special  = div_zero | div_ovf;

    // Results that need no iteration
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_is_rem(bus.in_op) ? bus.in_a : '1;
        end else if (div_ovf) begin
            special_res = op_is_rem(bus.in_op) ? '0 : bus.in_a;
        end
    end

    // ---------------- iteration: shift-add multiply / restoring divide ----------------
    // acc_q holds {high, low}: multiply {partial product, remaining multiplier},
    // divide {partial remainder, dividend shifting into quotient}.
    assign acc_hi = acc_q[2*XLEN-1:XLEN];
    assign acc_lo = acc_q[XLEN-1:0];

    assign mul_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_lo[XLEN-1:1]};

    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_diff[XLEN];
    assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_lo[XLEN-2:0], div_ge};

    // ---------------- fix: apply result sign ----------------
    // Select the half that holds the answer (low product / quotient or high product / remainder)
    always_comb begin
        fix_in = acc_lo;
        if (op_is_mulh(op_q) || (op_q == MD_REM) || (op_q == MD_REMU)) begin
            fix_in = acc_hi;
        end
    end

    muldiv_sign_conv #(.XLEN(XLEN)) u_fix (.din(fix_in), .neg(neg_q), .dout(fix_neg));

    // Upper half of a negated 2*XLEN product only takes the +1 carry when the low half is zero
    always_comb begin
        fix_res = fix_neg;
        if (neg_q && op_is_mulh(op_q) && (acc_lo != '0)) begin
            fix_res = ~acc_hi;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_d = ST_DONE;
                    end else if (op_is_div(bus.in_op)) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath registers: loaded on accept, stepped once per iteration cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= bus.in_op;
            neg_q <= neg_d;
            b_q   <= b_mag;
            acc_q <= {{XLEN{1'b0}}, a_mag};
            cnt_q <= '0;
        end else if (state_q == ST_MUL) begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + 1'b1;
        end else if (state_q == ST_DIV) begin
            acc_q <= div_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result and tag registers, held stable while DONE waits for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_result <= '0;
            bus.out_tag    <= '0;
        end else if (accept) begin
            bus.out_tag <= bus.in_tag;
            if (special) begin
                bus.out_result <= special_res;
            end
        end else if (state_q == ST_FIX) begin
            bus.out_result <= fix_res;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: arithmetic vectors, latency, output hold,
// flush and asynchronous reset behaviour.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LAT_NORMAL  = XLEN + 2;
    localparam int LAT_SPECIAL = 1;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;

    int n_chk;
    int n_fail;

    alu_muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge, then wait (bounded) for out_valid.
    // lat counts negedges after the accept edge: 1 = cycle right after it.
    task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] tag,
                          output logic [XLEN-1:0] res, output logic [TAG_W-1:0] rtag, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 200);
        if (!bus.out_valid) chk("timeout out_valid", 64'd0, 64'd1);
        res  = bus.out_result;
        rtag = bus.out_tag;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] exp, input int exp_lat);
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] rtag;
        int               lat;
        run_op(op, a, b, tag, res, rtag, lat);
        chk({name, " result"}, 64'(res), 64'(exp));
        chk({name, " tag"}, 64'(rtag), 64'(tag));
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        take();
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] rtag;
        int               lat;

        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("reset out_valid",  64'(bus.out_valid),  64'd0);
        chk("reset out_result", 64'(bus.out_result), 64'd0);
        chk("reset out_tag",    64'(bus.out_tag),    64'd0);
        chk("reset busy",       64'(busy),           64'd0);
        chk("reset in_ready",   64'(bus.in_ready),   64'd1);

        // Multiply family
        do_op("MUL 7*-3",    MD_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_NORMAL);
        do_op("MULHU ff*ff", MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, LAT_NORMAL);
        do_op("MULH min*min", MD_MULH,  32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, LAT_NORMAL);
        do_op("MULHSU -1*ff", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, LAT_NORMAL);
        do_op("MULH -3*5",   MD_MULH,   32'hFFFF_FFFD, 32'd5,        5'd9,  32'hFFFF_FFFF, LAT_NORMAL);

        // Divide family
        do_op("DIV -7/2",    MD_DIV,    32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFD, LAT_NORMAL);
        do_op("REM -7/2",    MD_REM,    32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFF, LAT_NORMAL);
        do_op("DIVU 100/7",  MD_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,        LAT_NORMAL);
        do_op("REMU 100/7",  MD_REMU,   32'd100,      32'd7,        5'd13, 32'd2,         LAT_NORMAL);
        do_op("DIV 7/-2",    MD_DIV,    32'd7,        32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, LAT_NORMAL);

        // Bypass cases
        do_op("DIV x/0",     MD_DIV,    32'd123,      32'd0,        5'd15, 32'hFFFF_FFFF, LAT_SPECIAL);
        do_op("REMU 5/0",    MD_REMU,   32'd5,        32'd0,        5'd16, 32'd5,         LAT_SPECIAL);
        do_op("DIV ovf",     MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, LAT_SPECIAL);
        do_op("REM ovf",     MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,        LAT_SPECIAL);

        // Result held while the consumer stalls
        run_op(MD_MUL, 32'd6, 32'd7, 5'd19, res, rtag, lat);
        chk("hold first result", 64'(res), 64'd42);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold out_valid", 64'(bus.out_valid),  64'd1);
            chk("hold result",    64'(bus.out_result), 64'd42);
            chk("hold tag",       64'(bus.out_tag),    64'd19);
            chk("hold in_ready",  64'(bus.in_ready),   64'd0);
        end
        take();
        @(negedge clk);
        chk("release out_valid", 64'(bus.out_valid), 64'd0);
        chk("release in_ready",  64'(bus.in_ready),  64'd1);
        chk("release busy",      64'(busy),          64'd0);

        // Flush during iteration 10 of a divide
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = MD_DIV;
        bus.in_a     = 32'd1000;
        bus.in_b     = 32'd3;
        bus.in_tag   = 5'd20;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy",     64'(busy),         64'd0);
        chk("flush in_ready", 64'(bus.in_ready), 64'd1);
        watch_quiet("flush no out_valid", 40);

        // Flush together with a request in IDLE: request dropped
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = MD_MUL;
        bus.in_a     = 32'd3;
        bus.in_b     = 32'd4;
        bus.in_tag   = 5'd21;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        chk("flush+req busy", 64'(busy), 64'd0);
        watch_quiet("flush+req no out_valid", 40);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = MD_DIVU;
        bus.in_a     = 32'd999;
        bus.in_b     = 32'd9;
        bus.in_tag   = 5'd22;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy",       64'(busy),           64'd0);
        chk("async rst out_valid",  64'(bus.out_valid),  64'd0);
        chk("async rst out_result", 64'(bus.out_result), 64'd0);
        chk("async rst out_tag",    64'(bus.out_tag),    64'd0);
        @(negedge clk) rst_n = 1'b1;
        watch_quiet("after rst no out_valid", 10);

        do_op("MUL 3*4", MD_MUL, 32'd3, 32'd4, 5'd23, 32'd12, LAT_NORMAL);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
